// File: rtl/sudoku_cell_stack.sv
// Puzzle cell: solved value + candidate mask with a DEPTH-deep snapshot stack for guess/backtrack.
// Latency: every strobe takes effect on the next clk edge; flags are registered from next state (never stale).
// No backpressure: push on full / pop on empty is dropped and sets sticky stack_err.
// Optional: define SUDOKU_CELL_POPCOUNT_READ_EN to read popcount(valid) at address 3.
module sudoku_cell_stack #(
  parameter int SYMBOLS = 9,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SYMBOLS:1] wdata,
  output logic [SYMBOLS:1] rdata,
  input  logic [1:0]       address,
  input  logic             we,
  input  logic             latch_singleton,
  input  logic             push,
  input  logic             pop,
  output logic             is_singleton,
  output logic             is_illegal,
  output logic             solved,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(SYMBOLS + 1);
  localparam int SW = 2 * SYMBOLS;

  // The status word packs {stack_err, depth} into rdata, so it must fit.
  if (SYMBOLS < DW + 1) begin : g_bad_width
    $error("sudoku_cell_stack: SYMBOLS too small to hold {stack_err, depth} in the status read");
  end

  function automatic logic [PW-1:0] popcnt(input logic [SYMBOLS:1] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 1; i <= SYMBOLS; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

  logic [SYMBOLS:1] value_q, value_d;
  logic [SYMBOLS:1] valid_q, valid_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             stack_err_q, stack_err_d;
  logic             is_singleton_q, is_singleton_d;
  logic             is_illegal_q, is_illegal_d;
  logic             solved_q, solved_d;
  logic             stack_full_q, stack_full_d;
  logic [SW-1:0]    stack_q [DEPTH];
  logic             push_ok;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign wr_idx = AW'(depth_q);
  assign rd_idx = AW'(depth_q - 1'b1);

  // Next-state: pop wins outright; otherwise push may pair with one update, we beating latch.
  always_comb begin
    value_d     = value_q;
    valid_d     = valid_q;
    depth_d     = depth_q;
    stack_err_d = stack_err_q;
    push_ok     = 1'b0;
    if (pop) begin
      if (depth_q != '0) begin
        {value_d, valid_d} = stack_q[rd_idx];
        depth_d            = depth_q - 1'b1;
      end else begin
        stack_err_d = 1'b1;
      end
    end else begin
      if (push) begin
        if (depth_q < DW'(DEPTH)) begin
          push_ok = 1'b1;
          depth_d = depth_q + 1'b1;
        end else begin
          stack_err_d = 1'b1;
        end
      end
      if (we) begin
        case (address)
          2'd0: begin
            value_d = wdata;
            valid_d = (wdata == '0) ? '1 : '0;
          end
          2'd1: begin
            valid_d = (value_q == '0) ? (valid_q & wdata) : '0;
          end
          default: ;
        endcase
      end else if (latch_singleton && is_singleton_q && (value_q == '0)) begin
        value_d = valid_q;
        valid_d = '0;
      end
    end
  end

  // Flags derive from next-state so they move on the same edge as the state they describe.
  always_comb begin
    is_singleton_d = (popcnt(valid_d) == PW'(1));
    is_illegal_d   = (value_d == '0) && (valid_d == '0);
    solved_d       = (value_d != '0);
    stack_full_d   = (depth_d == DW'(DEPTH));
  end

  // Cell state and flags; reset overrides every strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q        <= '0;
      valid_q        <= '1;
      depth_q        <= '0;
      stack_err_q    <= 1'b0;
      is_singleton_q <= (SYMBOLS == 1);
      is_illegal_q   <= 1'b0;
      solved_q       <= 1'b0;
      stack_full_q   <= 1'b0;
    end else begin
      value_q        <= value_d;
      valid_q        <= valid_d;
      depth_q        <= depth_d;
      stack_err_q    <= stack_err_d;
      is_singleton_q <= is_singleton_d;
      is_illegal_q   <= is_illegal_d;
      solved_q       <= solved_d;
      stack_full_q   <= stack_full_d;
    end
  end

  // Snapshot storage holds pre-edge state; contents are meaningless above depth, so no reset.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      stack_q[wr_idx] <= {value_q, valid_q};
    end
  end

  assign is_singleton = is_singleton_q;
  assign is_illegal   = is_illegal_q;
  assign solved       = solved_q;
  assign stack_full   = stack_full_q;
  assign stack_err    = stack_err_q;

`ifdef SUDOKU_CELL_POPCOUNT_READ_EN
  logic [SYMBOLS:1] aux_rd;
  assign aux_rd = SYMBOLS'(popcnt(valid_q));
`else
  logic [SYMBOLS:1] aux_rd;
  assign aux_rd = '0;
`endif

  // Register read mux; status zero-pads {stack_err, depth} into the low bits.
  always_comb begin
    rdata = '0;
    case (address)
      2'd0:    rdata = value_q;
      2'd1:    rdata = valid_q;
      2'd2:    rdata = SYMBOLS'({stack_err_q, depth_q});
      default: rdata = aux_rd;
    endcase
  end

endmodule

// File: tb/tb_sudoku_cell_stack.sv
// Bench for sudoku_cell_stack: directed ops, expectations queued, negedge monitor compares.
// Two instances: SYMBOLS=9 (main behaviour) and SYMBOLS=16 (wide flags and aux read).
// Prints one summary line and finishes.
module tb_sudoku_cell_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wdata;
  logic [1:0]  address;
  logic        we, latch_singleton, push, pop;

  logic [9:1]  rdata9;
  logic        sing9, ill9, solv9, full9, err9;
  logic [16:1] rdata16;
  logic        sing16, ill16, solv16, full16, err16;

  always #5 clk = ~clk;

  sudoku_cell_stack #(.SYMBOLS(9), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .wdata(wdata[8:0]), .rdata(rdata9), .address(address),
    .we(we), .latch_singleton(latch_singleton), .push(push), .pop(pop),
    .is_singleton(sing9), .is_illegal(ill9), .solved(solv9),
    .stack_full(full9), .stack_err(err9)
  );

  sudoku_cell_stack #(.SYMBOLS(16), .DEPTH(4)) u_dut16 (
    .clk(clk), .reset(reset), .wdata(wdata), .rdata(rdata16), .address(address),
    .we(we), .latch_singleton(latch_singleton), .push(push), .pop(pop),
    .is_singleton(sing16), .is_illegal(ill16), .solved(solv16),
    .stack_full(full16), .stack_err(err16)
  );

  // Expected flags are packed {is_singleton, is_illegal, solved, stack_full, stack_err}.
  typedef struct {
    string       name;
    bit          big;
    logic [15:0] rd;
    logic [4:0]  fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef SUDOKU_CELL_POPCOUNT_READ_EN
  localparam logic [15:0] AUX9_RST = 16'd9;
  localparam logic [15:0] AUX16    = 16'd4;
`else
  localparam logic [15:0] AUX9_RST = 16'd0;
  localparam logic [15:0] AUX16    = 16'd0;
`endif

  // Monitor: whenever an expectation is pending, compare it against the live outputs.
  always @(negedge clk) begin
    exp_t       e;
    logic [15:0] ard;
    logic [4:0]  afl;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.big) begin
        ard = rdata16;
        afl = {sing16, ill16, solv16, full16, err16};
      end else begin
        ard = {7'b0, rdata9};
        afl = {sing9, ill9, solv9, full9, err9};
      end
      checks++;
      if (ard !== e.rd) begin
        errors++;
        $display("FAIL %s rdata got %h want %h", e.name, ard, e.rd);
      end
      checks++;
      if (afl !== e.fl) begin
        errors++;
        $display("FAIL %s flags got %b want %b", e.name, afl, e.fl);
      end
    end
  end

  task automatic cyc(input bit w, input logic [1:0] a, input logic [15:0] d,
                     input bit l, input bit pu, input bit po);
    we = w; address = a; wdata = d; latch_singleton = l; push = pu; pop = po;
    @(posedge clk); #1;
    we = 1'b0; latch_singleton = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic chk(input string n, input bit big, input logic [1:0] ra,
                     input logic [15:0] rd, input logic [4:0] fl);
    exp_t e;
    address = ra;
    e.name = n; e.big = big; e.rd = rd; e.fl = fl;
    exp_q.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(0, 2'd0, 16'h0, 0, 0, 0);
    cyc(0, 2'd0, 16'h0, 0, 0, 0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; wdata = '0; address = '0;
    we = 1'b0; latch_singleton = 1'b0; push = 1'b0; pop = 1'b0;

    // Reset state
    do_reset();
    chk("rst_value", 0, 2'd0, 16'h000, 5'b00000);
    chk("rst_valid", 0, 2'd1, 16'h1FF, 5'b00000);
    chk("rst_status", 0, 2'd2, 16'h000, 5'b00000);
    chk("rst_aux", 0, 2'd3, AUX9_RST, 5'b00000);

    // Narrow to a singleton then latch it
    cyc(1, 2'd1, 16'h010, 0, 0, 0);
    chk("single_valid", 0, 2'd1, 16'h010, 5'b10000);
    cyc(0, 2'd0, 16'h000, 1, 0, 0);
    chk("latch_value", 0, 2'd0, 16'h010, 5'b00100);
    chk("latch_valid", 0, 2'd1, 16'h000, 5'b00100);
    cyc(0, 2'd0, 16'h000, 1, 0, 0);
    chk("relatch_value", 0, 2'd0, 16'h010, 5'b00100);

    // we beats latch_singleton in the same cycle
    do_reset();
    cyc(1, 2'd1, 16'h010, 0, 0, 0);
    cyc(1, 2'd1, 16'h030, 1, 0, 0);
    chk("we_over_latch_val", 0, 2'd0, 16'h000, 5'b10000);
    chk("we_over_latch_msk", 0, 2'd1, 16'h010, 5'b10000);

    // Illegal on same edge, then a value write resolves it
    do_reset();
    cyc(1, 2'd1, 16'h000, 0, 0, 0);
    chk("illegal", 0, 2'd1, 16'h000, 5'b01000);
    cyc(1, 2'd0, 16'h004, 0, 0, 0);
    chk("resolved_value", 0, 2'd0, 16'h004, 5'b00100);
    chk("resolved_valid", 0, 2'd1, 16'h000, 5'b00100);

    // Guess (push+we) and backtrack (pop)
    do_reset();
    cyc(1, 2'd1, 16'h00C, 0, 0, 0);
    cyc(1, 2'd0, 16'h004, 0, 1, 0);
    chk("guess_value", 0, 2'd0, 16'h004, 5'b00100);
    chk("guess_status", 0, 2'd2, 16'h001, 5'b00100);
    cyc(0, 2'd0, 16'h000, 0, 0, 1);
    chk("back_value", 0, 2'd0, 16'h000, 5'b00000);
    chk("back_valid", 0, 2'd1, 16'h00C, 5'b00000);
    chk("back_status", 0, 2'd2, 16'h000, 5'b00000);

    // Fill the stack and overflow it
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 16'h000, 0, 1, 0);
    chk("full_status", 0, 2'd2, 16'h004, 5'b00010);
    cyc(0, 2'd0, 16'h000, 0, 1, 0);
    chk("overflow_status", 0, 2'd2, 16'h00C, 5'b00011);

    // pop+we: only the pop lands
    cyc(1, 2'd0, 16'h020, 0, 0, 0);
    chk("pre_pop_value", 0, 2'd0, 16'h020, 5'b00111);
    cyc(1, 2'd0, 16'h002, 0, 0, 1);
    chk("popwe_value", 0, 2'd0, 16'h000, 5'b00001);
    chk("popwe_valid", 0, 2'd1, 16'h1FF, 5'b00001);
    chk("popwe_status", 0, 2'd2, 16'h00B, 5'b00001);

    // Underflow on an empty stack
    do_reset();
    chk("rst_clears_err", 0, 2'd2, 16'h000, 5'b00000);
    cyc(0, 2'd0, 16'h000, 0, 0, 1);
    chk("underflow_valid", 0, 2'd1, 16'h1FF, 5'b00001);
    chk("underflow_status", 0, 2'd2, 16'h008, 5'b00001);

    // 16-symbol instance: aux popcount read and wide singleton flag
    do_reset();
    chk("w16_rst_valid", 1, 2'd1, 16'hFFFF, 5'b00000);
    cyc(1, 2'd1, 16'h8421, 0, 0, 0);
    chk("w16_aux", 1, 2'd3, AUX16, 5'b00000);
    cyc(1, 2'd1, 16'h8000, 0, 0, 0);
    chk("w16_single", 1, 2'd1, 16'h8000, 5'b10000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain %0d expectations left, want 0", exp_q.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
